// File: rtl/muldiv_pkg.sv
// Purpose: shared op/state encodings and default sizing for the EX-stage mul/div unit.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    function automatic logic is_div(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Purpose: ID/EX-side request bundle and HI/LO result bundle of the mul/div unit.
// Latency: n/a (wires only).
// Backpressure: hold_pipe from the slave freezes the master's latch contents.
interface ex_muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] bus_a_in;
    logic [WIDTH-1:0] bus_b_in;
    logic             flush;
    logic             hold_pipe;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, op, bus_a_in, bus_b_in, flush,
        input  hold_pipe, busy, done, div_by_zero, hi_out, lo_out
    );

    modport slave (
        input  start, op, bus_a_in, bus_b_in, flush,
        output hold_pipe, busy, done, div_by_zero, hi_out, lo_out
    );
endinterface

// File: rtl/muldiv_step.sv
// Purpose: one radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the outputs.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 div_mode,
    input  logic [2*WIDTH-1:0]   prod_in,    // mul: running product; div: remainder in low word
    input  logic [2*WIDTH-1:0]   mcand_in,   // mul: shifted multiplicand; div: divisor in low word
    input  logic [WIDTH-1:0]     mq_in,      // mul: remaining multiplier; div: dividend/quotient
    output logic [2*WIDTH-1:0]   prod_out,
    output logic [2*WIDTH-1:0]   mcand_out,
    output logic [WIDTH-1:0]     mq_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Single iteration; the divide trial difference is negative exactly when bit WIDTH is set
    // because the partial remainder is always below the divisor.
    always_comb begin
        shifted   = {prod_in[WIDTH-1:0], mq_in[WIDTH-1]};
        diff      = shifted - {1'b0, mcand_in[WIDTH-1:0]};
        prod_out  = prod_in;
        mcand_out = mcand_in;
        mq_out    = mq_in;
        if (div_mode) begin
            prod_out = {{WIDTH{1'b0}}, (diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0])};
            mq_out   = {mq_in[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            prod_out  = prod_in + (mq_in[0] ? mcand_in : {2*WIDTH{1'b0}});
            mcand_out = mcand_in << 1;
            mq_out    = mq_in >> 1;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Purpose: iterative MULT/MULTU/DIV/DIVU unit at the ID/EX latch output; MULDIV_EARLY_OUT_EN ends multiplies early.
// Latency: start cycle + WIDTH busy + fix + done = done in cycle WIDTH+2; zero divisor done in cycle 2.
// Backpressure: hold_pipe freezes ID/EX and earlier latches from start through FIX; low in DONE.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic        clock,
    input  logic        reset_n,
    ex_muldiv_if.slave  mdu
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    op_e                  op_q;
    logic                 nsign_q;    // product / quotient sign
    logic                 rsign_q;    // remainder sign
    logic                 dz_q;
    logic [2*WIDTH-1:0]   prod_q, mcand_q, prod_nx, mcand_nx, mul_res;
    logic [WIDTH-1:0]     mq_q, mq_nx, hi_q, lo_q;
    logic [WIDTH-1:0]     a_mag, b_mag, quo_res, rem_res;
    op_e                  op_in;
    logic                 in_div, in_sgn, b_zero;

    assign op_in  = op_e'(mdu.op);
    assign in_div = is_div(op_in);
    assign in_sgn = is_signed_op(op_in);
    assign b_zero = (mdu.bus_b_in == '0);

    // Operand magnitudes; the most negative value maps onto itself, which is its correct unsigned magnitude.
    always_comb begin
        a_mag = (in_sgn && mdu.bus_a_in[WIDTH-1]) ? -mdu.bus_a_in : mdu.bus_a_in;
        b_mag = (in_sgn && mdu.bus_b_in[WIDTH-1]) ? -mdu.bus_b_in : mdu.bus_b_in;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode  (is_div(op_q)),
        .prod_in   (prod_q),
        .mcand_in  (mcand_q),
        .mq_in     (mq_q),
        .prod_out  (prod_nx),
        .mcand_out (mcand_nx),
        .mq_out    (mq_nx)
    );

    // Sign-corrected results, consumed only on the FIX edge.
    always_comb begin
        mul_res = nsign_q ? -prod_q : prod_q;
        quo_res = nsign_q ? -mq_q : mq_q;
        rem_res = rsign_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state: flush overrides everything; DONE never re-accepts the still-latched start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mdu.start) state_d = (in_div && b_zero) ? ST_FIX : ST_BUSY;
            ST_BUSY: begin
                if (cnt_q == CNT_W'(WIDTH-1)) state_d = ST_FIX;
`ifdef MULDIV_EARLY_OUT_EN
                else if (!is_div(op_q) && (mq_nx == '0)) state_d = ST_FIX;
`endif
            end
            ST_FIX:  state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        if (mdu.flush) state_d = ST_IDLE;
    end

    // Outputs: status is forced low while reset is asserted, even before the reset edge.
    always_comb begin
        mdu.busy        = reset_n && (state_q != ST_IDLE);
        mdu.hold_pipe   = reset_n && (((state_q == ST_IDLE) && mdu.start && !mdu.flush) ||
                                      (state_q == ST_BUSY) || (state_q == ST_FIX));
        mdu.done        = reset_n && (state_q == ST_DONE);
        mdu.div_by_zero = reset_n && (state_q == ST_DONE) && dz_q;
        mdu.hi_out      = hi_q;
        mdu.lo_out      = lo_q;
    end

    // Datapath: load operands on start, iterate in BUSY, commit HI/LO in FIX; flush freezes all of it.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            nsign_q <= 1'b0;
            rsign_q <= 1'b0;
            dz_q    <= 1'b0;
            prod_q  <= '0;
            mcand_q <= '0;
            mq_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (!mdu.flush) begin
            case (state_q)
                ST_IDLE: if (mdu.start) begin
                    op_q    <= op_in;
                    cnt_q   <= '0;
                    nsign_q <= in_sgn && (mdu.bus_a_in[WIDTH-1] ^ mdu.bus_b_in[WIDTH-1]);
                    rsign_q <= in_sgn && mdu.bus_a_in[WIDTH-1];
                    mcand_q <= {{WIDTH{1'b0}}, (in_div ? b_mag : a_mag)};
                    if (in_div && b_zero) begin
                        dz_q   <= 1'b1;
                        prod_q <= {{WIDTH{1'b0}}, mdu.bus_a_in};
                        mq_q   <= '1;
                    end else begin
                        dz_q   <= 1'b0;
                        prod_q <= '0;
                        mq_q   <= in_div ? a_mag : b_mag;
                    end
                end
                ST_BUSY: begin
                    prod_q  <= prod_nx;
                    mcand_q <= mcand_nx;
                    mq_q    <= mq_nx;
                    cnt_q   <= cnt_q + 1'b1;
                end
                ST_FIX: begin
                    if (dz_q) begin
                        hi_q <= prod_q[WIDTH-1:0];
                        lo_q <= mq_q;
                    end else if (is_div(op_q)) begin
                        hi_q <= rem_res;
                        lo_q <= quo_res;
                    end else begin
                        hi_q <= mul_res[2*WIDTH-1:WIDTH];
                        lo_q <= mul_res[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Purpose: directed self-checking bench for ex_muldiv with a result scoreboard.
// Latency: checks done cycle, hold_pipe window and HI/LO per operation.
// Backpressure: models the ID/EX latch holding start until the done cycle.
module tb_ex_muldiv;
    import muldiv_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    ex_muldiv_if #(.WIDTH(32)) mdu();

    ex_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .mdu     (mdu)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          done_seen = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int CYC_NEG3X7 = 5;
    localparam int CYC_5X0    = 3;
    localparam int CYC_X10    = 7;
`else
    localparam int CYC_NEG3X7 = 34;
    localparam int CYC_5X0    = 34;
    localparam int CYC_X10    = 34;
`endif

    always @(negedge clock) if (mdu.done) done_seen++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Holds start (as the frozen ID/EX latch would) until done, checking hold_pipe and the scoreboard.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                          input int ecyc, input bit release_after);
        exp_t e;
        bit   got;
        bit   hold_ok;
        e.hi = ehi; e.lo = elo; e.dz = edz; e.cyc = ecyc;
        sb.push_back(e);
        got = 0;
        hold_ok = 1;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clock);
            mdu.start = 1'b1; mdu.op = o; mdu.bus_a_in = a; mdu.bus_b_in = b; mdu.flush = 1'b0;
            #1;
            if (mdu.done) begin
                e = sb.pop_front();
                check({name, ".hi"}, 64'(mdu.hi_out), 64'(e.hi));
                check({name, ".lo"}, 64'(mdu.lo_out), 64'(e.lo));
                check({name, ".dz"}, 64'(mdu.div_by_zero), 64'(e.dz));
                check({name, ".cycle"}, 64'(c), 64'(e.cyc));
                check({name, ".hold_in_done"}, 64'(mdu.hold_pipe), 64'd0);
                got = 1;
            end else if (!mdu.hold_pipe) begin
                hold_ok = 0;
            end
        end
        check({name, ".reached_done"}, 64'(got), 64'd1);
        check({name, ".hold_window"}, 64'(hold_ok), 64'd1);
        last_hi = ehi;
        last_lo = elo;
        if (release_after) begin
            @(negedge clock);
            mdu.start = 1'b0;
            #1;
            check({name, ".single_pulse"}, 64'({mdu.done, mdu.div_by_zero}), 64'd0);
        end
    endtask

    initial begin
        int d0;
        mdu.start = 1'b0; mdu.op = 2'b00; mdu.bus_a_in = '0; mdu.bus_b_in = '0; mdu.flush = 1'b0;

        // Reset state; start during reset must not raise hold_pipe.
        repeat (3) @(negedge clock);
        mdu.start = 1'b1;
        #1;
        check("rst.hi", 64'(mdu.hi_out), 64'd0);
        check("rst.lo", 64'(mdu.lo_out), 64'd0);
        check("rst.status", 64'({mdu.busy, mdu.hold_pipe, mdu.done, mdu.div_by_zero}), 64'd0);
        @(negedge clock);
        mdu.start = 1'b0;
        reset_n = 1'b1;

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, 1);
        run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, CYC_NEG3X7, 1);
        run_op("mult_5x0", 2'b00, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0, CYC_5X0, 1);
        run_op("mult_min_sq", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 34, 1);
        run_op("div_neg7by2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 1);
        run_op("div_7byneg2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 34, 1);
        run_op("divu_100by7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 1);
        run_op("div_min_by_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34, 1);
        run_op("divu_by0", 2'b11, 32'h64, 32'd0, 32'h64, 32'hFFFF_FFFF, 1'b1, 2, 1);
        run_op("div_neg5_by0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 2, 1);

        // Back-to-back: start stays high across DONE, latch reloads with the second instruction.
        d0 = done_seen;
        run_op("b2b_first", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, 0);
        run_op("b2b_second", 2'b01, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, 1'b0, CYC_X10, 1);
        check("b2b.done_pulses", 64'(done_seen - d0), 64'd2);

        // Flush in cycle 10 of a DIV (start still latched): idle next cycle, no done, HI/LO kept.
        d0 = done_seen;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clock);
            mdu.start = 1'b1; mdu.op = 2'b10; mdu.bus_a_in = 32'd100; mdu.bus_b_in = 32'd7;
            mdu.flush = (c == 10);
        end
        @(negedge clock);
        mdu.start = 1'b0; mdu.flush = 1'b0;
        #1;
        check("flush.idle", 64'({mdu.busy, mdu.hold_pipe}), 64'd0);
        repeat (40) @(negedge clock);
        #1;
        check("flush.no_done", 64'(done_seen - d0), 64'd0);
        check("flush.hi_kept", 64'(mdu.hi_out), 64'(last_hi));
        check("flush.lo_kept", 64'(mdu.lo_out), 64'(last_lo));

        // Reset in cycle 20 of a MULT.
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            mdu.start = 1'b1; mdu.op = 2'b00; mdu.bus_a_in = 32'hFFFF_FFFD; mdu.bus_b_in = 32'h7FFF_FFFF;
        end
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("rstmid.comb_status", 64'({mdu.busy, mdu.hold_pipe}), 64'd0);
        @(negedge clock);
        #1;
        check("rstmid.hi", 64'(mdu.hi_out), 64'd0);
        check("rstmid.lo", 64'(mdu.lo_out), 64'd0);
        check("rstmid.status", 64'({mdu.busy, mdu.hold_pipe, mdu.done, mdu.div_by_zero}), 64'd0);
        mdu.start = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        check("rstmid.idle_after", 64'({mdu.busy, mdu.done}), 64'd0);
        check("sb.empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
